// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC channel sequencer.
// Holds the sequencer FSM state, stream field layout and slot-width helper.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } seq_state_e;

  localparam int unsigned STREAM_SLOT_LSB   = 16;
  localparam int unsigned ERROR_COUNT_WIDTH = 8;

  // Bits needed to index n slots, never less than one.
  function automatic int unsigned slot_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/adc_channel_sequencer_if.sv
// Avalon-ST command/response pair towards the ADC plus the stb/ack result stream.
// master = sequencer side, slave = ADC core and stream consumer side.
interface adc_channel_sequencer_if #(
  parameter int unsigned CHANNEL_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 12
);

  logic                     command_valid;
  logic [CHANNEL_WIDTH-1:0] command_channel;
  logic                     command_startofpacket;
  logic                     command_endofpacket;
  logic                     command_ready;
  logic                     response_valid;
  logic [CHANNEL_WIDTH-1:0] response_channel;
  logic [DATA_WIDTH-1:0]    response_data;
  logic [31:0]              stream_out;
  logic                     stream_stb_out;
  logic                     stream_ack_in;

  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready,
    input  response_valid, response_channel, response_data,
    output stream_out, stream_stb_out,
    input  stream_ack_in
  );

  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready,
    output response_valid, response_channel, response_data,
    input  stream_out, stream_stb_out,
    output stream_ack_in
  );

endinterface

// File: rtl/adc_seq_averager.sv
// One slot's sample accumulator: sums 2^AVG_LOG2 accepted samples, then registers
// the truncated mean. done/avg are combinational so the top can stream the same cycle.
module adc_seq_averager #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_stb,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] avg,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  localparam int unsigned AccW = DATA_WIDTH + AVG_LOG2;

  logic [AccW-1:0]       acc_q, acc_d, sum;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  valid_q;

  assign sum = acc_q + AccW'(sample);
  assign avg = sum[AccW-1:AVG_LOG2];

  if (AVG_LOG2 > 0) begin : g_cnt
    logic [AVG_LOG2-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (sample_stb) begin
        cnt_q <= cnt_q + AVG_LOG2'(1);
      end
    end

    assign done = sample_stb && (cnt_q == '1);
  end else begin : g_nocnt
    assign done = sample_stb;
  end

  // The final sample goes into the result, not into the next window.
  always_comb begin
    acc_d = acc_q;
    if (done) begin
      acc_d = '0;
    end else if (sample_stb) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (done) begin
        result_q <= avg;
        valid_q  <= 1'b1;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin MAX10 ADC sequencer with response checking, per-slot averaging and a result
// stream. Define ADC_SEQ_PEAK_EN to add per-slot peak tracking (peak_out / peak_clr_in).
module adc_channel_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned CHANNEL_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_map,
  adc_channel_sequencer_if.master             bus,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  samples_out,
  output logic [NUM_CHANNELS-1:0]             samples_valid_out,
  output logic                                overflow_out,
  output logic [ERROR_COUNT_WIDTH-1:0]        error_count_out
`ifdef ADC_SEQ_PEAK_EN
  ,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  peak_out,
  input  logic                                peak_clr_in
`endif
);

  localparam int unsigned SlotW  = slot_width(NUM_CHANNELS);
  localparam int unsigned TimerW = slot_width(TIMEOUT + 1);

  seq_state_e                   state_q, state_d;
  logic [SlotW-1:0]             slot_q, slot_d, next_slot;
  logic [CHANNEL_WIDTH-1:0]     chan_q, chan_d, map_chan;
  logic [TimerW-1:0]            timer_q, timer_d;
  logic [ERROR_COUNT_WIDTH-1:0] err_q;
  logic [31:0]                  stream_q, stream_word;
  logic                         stb_q, ovf_q;
  logic                         in_wait, match, accept, mismatch, timeout, new_avg;
  logic [NUM_CHANNELS-1:0]      slot_stb, slot_done;
  logic [DATA_WIDTH-1:0]        slot_avg [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]        cur_avg;

  assign map_chan  = channel_map[slot_q*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  assign next_slot = (32'(slot_q) == NUM_CHANNELS - 1) ? '0 : slot_q + SlotW'(1);

  assign in_wait  = (state_q == StWait);
  assign match    = (bus.response_channel == chan_q);
  assign accept   = in_wait && bus.response_valid && match;
  assign mismatch = in_wait && bus.response_valid && !match;
  assign timeout  = in_wait && !accept && (32'(timer_q) + 32'd1 >= TIMEOUT);

  always_comb begin
    state_d             = state_q;
    slot_d              = slot_q;
    chan_d              = chan_q;
    timer_d             = timer_q;
    bus.command_valid   = 1'b0;
    bus.command_channel = '0;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StIssue;
      end
      StIssue: begin
        bus.command_valid   = 1'b1;
        bus.command_channel = map_chan;
        if (bus.command_ready) begin
          state_d = StWait;
          chan_d  = map_chan;
          timer_d = '0;
        end
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (accept) begin
          state_d = enable ? StIssue : StIdle;
          slot_d  = next_slot;
        end else if (timeout) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.command_startofpacket = bus.command_valid;
  assign bus.command_endofpacket   = bus.command_valid;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_slot
    assign slot_stb[i] = accept && (32'(slot_q) == i);

    adc_seq_averager #(
      .DATA_WIDTH (DATA_WIDTH),
      .AVG_LOG2   (AVG_LOG2)
    ) u_avg (
      .clk          (clk),
      .rst          (rst),
      .sample_stb   (slot_stb[i]),
      .sample       (bus.response_data),
      .done         (slot_done[i]),
      .avg          (slot_avg[i]),
      .result       (samples_out[i*DATA_WIDTH +: DATA_WIDTH]),
      .result_valid (samples_valid_out[i])
    );

`ifdef ADC_SEQ_PEAK_EN
    logic [DATA_WIDTH-1:0] peak_q;

    // A sample accepted alongside a clear seeds the new peak.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        peak_q <= '0;
      end else if (peak_clr_in) begin
        peak_q <= slot_stb[i] ? bus.response_data : '0;
      end else if (slot_stb[i] && (bus.response_data > peak_q)) begin
        peak_q <= bus.response_data;
      end
    end

    assign peak_out[i*DATA_WIDTH +: DATA_WIDTH] = peak_q;
`endif
  end

  assign new_avg     = |slot_done;
  assign cur_avg     = slot_avg[slot_q];
  assign stream_word = (32'(slot_q) << STREAM_SLOT_LSB) | 32'(cur_avg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      chan_q   <= '0;
      timer_q  <= '0;
      err_q    <= '0;
      stream_q <= '0;
      stb_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      chan_q  <= chan_d;
      timer_q <= timer_d;
      if ((mismatch || timeout) && (err_q != '1)) begin
        err_q <= err_q + ERROR_COUNT_WIDTH'(1);
      end
      // A word being acked this cycle frees the slot for the new result.
      if (new_avg) begin
        if (!stb_q || bus.stream_ack_in) begin
          stream_q <= stream_word;
          stb_q    <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (bus.stream_ack_in) begin
        stb_q <= 1'b0;
      end
    end
  end

  assign bus.stream_out     = stream_q;
  assign bus.stream_stb_out = stb_q;
  assign overflow_out       = ovf_q;
  assign error_count_out    = err_q;

endmodule

// File: doc/adc_channel_sequencer.md
Name: adc_channel_sequencer

Overview:
Parametrised successor to the fixed "command_valid=1" tie-off on the MAX10 built-in ADC. It round-robins over NUM_CHANNELS runtime-selectable ADC channels, one conversion in flight at a time, and checks each response. It averages 2^AVG_LOG2 samples per channel and presents the results two ways: as parallel per-channel registers for the transceiver, and as a stb/ack word stream for the control CPU (the adc_in path).

Parameters:
NUM_CHANNELS, 4, number of sequenced slots (1..16)
CHANNEL_WIDTH, 5, ADC channel number width
DATA_WIDTH, 12, ADC sample width (<=16)
AVG_LOG2, 2, samples averaged per result = 2^AVG_LOG2 (0 = no averaging)
TIMEOUT, 255, cycles to wait for a response before retrying

Ports:
clk  in  1  ADC-domain clock (clk_10)
rst  in  1  asynchronous active-high reset
enable  in  1  run sequencer
channel_map  in  NUM_CHANNELS*CHANNEL_WIDTH  ADC channel per slot, slot 0 in LSBs
command_valid  out  1  Avalon-ST command valid
command_channel  out  CHANNEL_WIDTH  channel requested
command_startofpacket  out  1  always equal to command_valid
command_endofpacket  out  1  always equal to command_valid
command_ready  in  1  ADC accepts command
response_valid  in  1  sample valid
response_channel  in  CHANNEL_WIDTH  sample's channel
response_data  in  DATA_WIDTH  sample
samples_out  out  NUM_CHANNELS*DATA_WIDTH  latest average per slot
samples_valid_out  out  NUM_CHANNELS  slot has produced at least one average
stream_out  out  32  {12'b0, slot[3:0], zero-extended average[15:0]}
stream_stb_out  out  1  stream word valid
stream_ack_in  in  1  consumer accepts word
overflow_out  out  1  sticky: a result was dropped because the stream was busy
error_count_out  out  8  saturating count of timeouts and channel mismatches

Behaviour:
- Reset: all outputs 0. FSM = IDLE, slot = 0, accumulators and sample counters cleared.
- FSM IDLE: if enable, go to ISSUE.
- FSM ISSUE: command_valid=1, command_channel=channel_map[slot]. On command_ready go to WAIT; the timer is cleared on entry to WAIT. channel_map is sampled in the cycle the command is accepted.
- FSM WAIT: a response_valid with response_channel equal to the issued channel is accepted. Accumulate, then advance slot (wrap NUM_CHANNELS-1 -> 0). Next state is ISSUE if enable, else IDLE.
- WAIT, mismatched channel: the sample is discarded, error_count increments, and the FSM stays in WAIT. The timer is not reset.
- WAIT, timer reaches TIMEOUT: error_count increments and the FSM returns to ISSUE for the same slot, with no accumulation.
- Clearing enable mid-conversion: the in-flight response is completed, then the FSM goes to IDLE. Accumulators are retained.
- Accumulator per slot is DATA_WIDTH+AVG_LOG2 bits, with a per-slot counter of AVG_LOG2 bits. When the counter wraps to 0:
  - the average (acc >> AVG_LOG2, truncating) is written to samples_out[slot] the next cycle;
  - samples_valid_out[slot] is set;
  - the accumulator is reloaded with the current sample's contribution set to 0, i.e. the accumulator is cleared;
  - result latency is 1 cycle after the final response_valid.
- Stream, on each new average: if stream_stb_out=0 or (stream_stb_out & stream_ack_in) in that cycle, load stream_out and set stream_stb_out. Otherwise drop the result and set overflow_out (sticky until rst).
- stream_stb_out clears the cycle after ack unless it is reloaded in that same cycle. stream_out is stable while stb=1 and ack=0.
- error_count_out saturates at 255.
- Only one command is ever outstanding. A response_valid seen in IDLE or ISSUE is ignored and is not counted.

Optional Feature:
ADC_SEQ_PEAK_EN:
- With the macro defined: adds output peak_out (NUM_CHANNELS*DATA_WIDTH) and input peak_clr_in (1).
  - Per slot, peak_out holds the maximum raw accepted sample since reset or since the last peak_clr_in.
  - peak_clr_in=1 sets every peak to 0. An accepted sample in the same cycle becomes the new peak.
- With the macro undefined: those ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package adc_seq_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT);
  - constants for STREAM_SLOT_LSB=16 and ERROR_COUNT_WIDTH=8;
  - a slot-index width function clog2(NUM_CHANNELS).
- One natural sub-module: adc_seq_averager. It holds one slot's accumulator, counter and result register, and is instantiated NUM_CHANNELS times with a per-slot sample strobe.

Test Plan:
1. NUM_CHANNELS=4, AVG_LOG2=0, map {3,2,1,0}; model returns channel+0x100 one cycle after ready. Expect commands on channels 0,1,2,3,0 in order; samples_out = {0x103,0x102,0x101,0x100}; four stream words with slots 0..3 and error_count=0.
2. AVG_LOG2=2, slot 0 responses 10,11,12,13. Expect samples_out[0]=11 one cycle after the 4th response, and no stream word before then.
3. Model withholds the response; TIMEOUT=255. Expect command_valid to reassert for the same channel 256 cycles after acceptance, and error_count=1.
4. Model returns channel 7 while channel 1 is expected, then channel 1. Expect error_count=1 and only the channel-1 sample accumulated.
5. Hold stream_ack_in=0 across two results. Expect the first word held stable, overflow_out=1, and the second result still in samples_out.
6. Assert rst mid-WAIT, then drop enable mid-conversion. Expect all outputs at 0 immediately on rst. With enable low, the FSM reaches IDLE after the pending response and issues no new command.
